vga_frame_scanout: RTL and testbench
====================================

Name: vga_frame_scanout

Overview:
- Reader side of the 320x240x12-bit VGA frame buffer RAM.
- Generates 640x480@60 Hz VGA timing from a pixel-clock enable.
- Issues row/column read addresses into the buffer, upscaling each image pixel 2x2.
- Drives registered 4:4:4 RGB and active-low syncs to the board DAC/connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMAGE_WIDTH, 320, buffer columns
- IMAGE_HEIGHT, 240, buffer rows
- READ_LATENCY, 1, pix_en strobes between address issue and pixel_in valid; legal values 1 or 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe, one per pixel time (25 MHz rate); logic advances only when high
- row_read  out  8  buffer row address
- col_read  out  9  buffer column address
- pixel_in  in  12  buffer read data, {R[11:8], G[7:4], B[3:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- active_video  out  1  high while RGB is in the visible region (aligned with RGB)
- frame_start  out  1  one-clk pulse on the first visible pixel of each frame (aligned with RGB)

Behaviour:
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0; row_read = col_read = 0.
  - vga_r/g/b = 0; vga_hsync = vga_vsync = 1; active_video = 0; frame_start = 0.
  - The delay pipeline is cleared.
- Reset mid-frame: all outputs take their reset values immediately. After release, the frame restarts at h_cnt = v_cnt = 0.
- Counters:
  - On pix_en, h_cnt increments 0..H_TOTAL-1 (800) and wraps to 0.
  - On that wrap, v_cnt increments 0..V_TOTAL-1 (525) and wraps to 0.
  - When pix_en is low, all state holds.
- Raw timing, stage 0:
  - vis = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_n is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vs_n is low for v_cnt in [490, 491].
- Address generation (registered, updated on pix_en):
  - If vis: col_read = h_cnt[9:1], row_read = v_cnt[8:1].
  - Else: both = 0. Addresses never exceed 319/239.
- Delay pipeline:
  - vis, hs_n, vs_n and first = (h_cnt == 0 && v_cnt == 0) are delayed by READ_LATENCY+1 pix_en strobes (the +1 is the address register), so they align with pixel_in.
  - On the pix_en that captures pixel_in:
    - delayed vis = 1: vga_r = pixel_in[11:8], vga_g = pixel_in[7:4], vga_b = pixel_in[3:0].
    - delayed vis = 0: RGB = 0.
  - active_video and the syncs register in the same cycle as RGB.
- frame_start: high for exactly one clk, in the cycle the delayed first flag registers. It is low in all other cycles, including cycles with pix_en low.
- Total output latency, counter to pins: READ_LATENCY+1 pix_en strobes. It is constant, so sync-to-video alignment matches VESA 640x480.
- pix_en held continuously high: the block runs at clk rate; the same rules apply.
- pix_en gaps are allowed at any point. Outputs hold their last values and no sample is lost.
- Widths: h_cnt is 10 bits and v_cnt is 10 bits. Comparisons are unsigned.

Test Plan:
- Reset then 800x525 pix_en strobes (READ_LATENCY=1):
  - hsync low for exactly 96 strobes starting output index 656+2 per line.
  - vsync low for 2 lines (490-491), 1600 strobes.
  - Frame period is 420000 strobes.
- Buffer model with data = {row[3:0], col[7:0]}:
  - Output pixel (x=5, y=7) shows the data at row 3, col 2.
  - Pixels (4..5, 6..7) all equal that same value.
- Blanking: model returns 12'hFFF everywhere.
  - RGB = 0 and active_video = 0 for h_cnt 640-799 and lines 480-524.
  - RGB = F/F/F when visible.
- Address bounds: across a full frame, col_read ≤ 319 and row_read ≤ 239. Both are 0 during blanking.
- pix_en pattern 1-0-0-1 (every third clk):
  - Timing is identical in strobe counts.
  - frame_start is one clk wide, exactly once per 420000 strobes.
- Assert rst_n low at h_cnt = 300, v_cnt = 100:
  - Outputs reset asynchronously (hsync = 1, RGB = 0).
  - After release, first visible pixel emerges READ_LATENCY+1 strobes later with frame_start = 1.

Source files
------------

// File: rtl/vga_frame_scanout.sv
// Reader side of a 320x240x12 frame buffer: 640x480@60 VGA timing, 2x2 pixel
// upscale addressing and registered RGB/sync outputs aligned to RAM read latency.
module vga_frame_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [7:0]  row_read,
  output logic [8:0]  col_read,
  input  logic [11:0] pixel_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        active_video,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  // One stage for the address register plus one per RAM latency strobe.
  localparam int DEPTH    = READ_LATENCY + 1;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic first;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  logic [9:0]            h_cnt_q, h_cnt_d;
  logic [9:0]            v_cnt_q, v_cnt_d;
  logic [7:0]            row_read_q, row_read_d;
  logic [8:0]            col_read_q, col_read_d;
  ctl_t [DEPTH-1:0]      ctl_pipe_q, ctl_pipe_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  active_q, active_d;
  logic                  frame_start_q, frame_start_d;

  ctl_t                  ctl_p0;
  ctl_t                  ctl_out;
  logic [8:0]            col_full;
  logic [7:0]            row_full;
  logic [8:0]            col_addr;
  logic [7:0]            row_addr;

  // Stage 0: counters and raw timing decode
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == 10'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    ctl_p0       = CTL_IDLE;
    ctl_p0.vis   = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    ctl_p0.hs_n  = !((h_cnt_q >= 10'(HS_START)) && (h_cnt_q < 10'(HS_END)));
    ctl_p0.vs_n  = !((v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_END)));
    ctl_p0.first = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  // Stage 1: 2x2 upscale addressing, clamped so a mismatched timing set can never
  // address past the buffer.
  always_comb begin
    col_full = h_cnt_q[9:1];
    row_full = v_cnt_q[8:1];
    col_addr = (col_full > 9'(IMAGE_WIDTH - 1))  ? 9'(IMAGE_WIDTH - 1)  : col_full;
    row_addr = (row_full > 8'(IMAGE_HEIGHT - 1)) ? 8'(IMAGE_HEIGHT - 1) : row_full;

    col_read_d = col_read_q;
    row_read_d = row_read_q;
    ctl_pipe_d = ctl_pipe_q;
    if (pix_en) begin
      col_read_d = ctl_p0.vis ? col_addr : '0;
      row_read_d = ctl_p0.vis ? row_addr : '0;
      ctl_pipe_d = {ctl_pipe_q[DEPTH-2:0], ctl_p0};
    end
  end

  // Output stage: capture pixel_in alongside its delayed control flags
  always_comb begin
    ctl_out       = ctl_pipe_q[DEPTH-1];
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      rgb_d         = ctl_out.vis ? pixel_in : 12'h000;
      hsync_d       = ctl_out.hs_n;
      vsync_d       = ctl_out.vs_n;
      active_d      = ctl_out.vis;
      frame_start_d = ctl_out.first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      row_read_q    <= '0;
      col_read_q    <= '0;
      ctl_pipe_q    <= {DEPTH{CTL_IDLE}};
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      row_read_q    <= row_read_d;
      col_read_q    <= col_read_d;
      ctl_pipe_q    <= ctl_pipe_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_read     = row_read_q;
  assign col_read     = col_read_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];
  assign vga_hsync    = hsync_q;
  assign vga_vsync    = vsync_q;
  assign active_video = active_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Scoreboard bench for vga_frame_scanout on a shrunken timing set so whole
// frames fit in a short run; a synchronous RAM model feeds pixel_in.
module tb_vga_frame_scanout;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int IW = 8, IH = 6, RL = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic [11:0] pixel_in;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, active_video, frame_start;
  logic [15:0] obs;

  typedef struct {
    logic [15:0] e;
    int          x;
    int          y;
  } sb_t;

  sb_t         sb_q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          h_m, v_m, stb_idx, last_fs, first_fs;
  int          hs_low, vs_low, fs_cnt, av_cnt;
  bit          pattern_mode = 1'b1;
  logic [11:0] img [VA][HA];
  logic [11:0] ram_q [RL] = '{default: 12'h000};

  always #5 clk = ~clk;

  vga_frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .row_read(row_read), .col_read(col_read), .pixel_in(pixel_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .active_video(active_video), .frame_start(frame_start)
  );

  assign obs = {active_video, vga_hsync, vga_vsync, frame_start, vga_r, vga_g, vga_b};

  function automatic logic [11:0] mem_data(input logic [7:0] r, input logic [8:0] c);
    return pattern_mode ? {r[3:0], c[7:0]} : 12'hFFF;
  endfunction

  always @(posedge clk) begin
    if (pix_en) begin
      ram_q[0] <= mem_data(row_read, col_read);
      for (int i = 1; i < RL; i++) ram_q[i] <= ram_q[i-1];
    end
  end
  assign pixel_in = ram_q[RL-1];

  function automatic logic [15:0] exp_out(input int h, input int v);
    logic vis, hs_n, vs_n, fs;
    logic [11:0] rgb;
    vis  = (h < HA) && (v < VA);
    hs_n = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs_n = !((v >= VA + VFP) && (v < VA + VFP + VS));
    fs   = (h == 0) && (v == 0);
    rgb  = vis ? mem_data(8'(v / 2), 9'(h / 2)) : 12'h000;
    return {vis, hs_n, vs_n, fs, rgb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp_cnt++;
    assert (o === e) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic init_model();
    sb_t s;
    h_m = 0; v_m = 0; stb_idx = 0; last_fs = -1; first_fs = -1;
    sb_q.delete();
    s.e = 16'h6000; s.x = -1; s.y = -1;
    repeat (RL + 1) sb_q.push_back(s);
  endtask

  // Called at a negedge; drives one clk with pix_en=en and checks the result.
  task automatic step(input bit en);
    sb_t s;
    logic [15:0] prev;
    bit vis_m;
    prev = obs;
    pix_en = en;
    if (en) begin
      s.e = exp_out(h_m, v_m); s.x = h_m; s.y = v_m;
      sb_q.push_back(s);
    end
    @(posedge clk);
    @(negedge clk);
    if (!en) begin
      chk("hold", obs, {prev[15:13], 1'b0, prev[11:0]});
      return;
    end
    s = sb_q.pop_front();
    chk("out", obs, s.e);
    if (s.x >= 0 && s.e[15]) img[s.y][s.x] = {vga_r, vga_g, vga_b};
    vis_m = (h_m < HA) && (v_m < VA);
    chk("col", col_read, vis_m ? h_m / 2 : 0);
    chk("row", row_read, vis_m ? v_m / 2 : 0);
    if (!vga_hsync) hs_low++;
    if (!vga_vsync) vs_low++;
    if (active_video) av_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (first_fs < 0) first_fs = stb_idx;
      if (last_fs >= 0) chk("fs_period", stb_idx - last_fs, FRAME);
      last_fs = stb_idx;
    end
    stb_idx++;
    if (h_m == HT - 1) begin
      h_m = 0;
      v_m = (v_m == VT - 1) ? 0 : v_m + 1;
    end else begin
      h_m++;
    end
  endtask

  task automatic run_window(input bit gaps, input string tag);
    hs_low = 0; vs_low = 0; fs_cnt = 0; av_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1);
      if (gaps) begin
        step(1'b0);
        step(1'b0);
      end
    end
    chk({tag, "_hs_low"}, hs_low, HS * VT);
    chk({tag, "_vs_low"}, vs_low, VS * HT);
    chk({tag, "_fs_cnt"}, fs_cnt, 1);
    chk({tag, "_av_cnt"}, av_cnt, HA * VA);
  endtask

  task automatic goto_blank_switch(input bit mode);
    for (int i = 0; i < FRAME && !(v_m == VA + 1 && h_m == 0); i++) step(1'b1);
    pattern_mode = mode;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_obs", obs, 16'h6000);
    chk("rst_row", row_read, 0);
    chk("rst_col", col_read, 0);
    rst_n = 1'b1;
    init_model();
    step(1'b1);
    step(1'b1);
    run_window(1'b0, "cont");

    chk("px_5_7", img[7][5], 12'h302);
    chk("px_4_6", img[6][4], 12'h302);
    chk("px_5_6", img[6][5], 12'h302);
    chk("px_4_7", img[7][4], 12'h302);
    chk("px_6_7", img[7][6], 12'h303);

    goto_blank_switch(1'b0);
    run_window(1'b0, "fff");

    goto_blank_switch(1'b1);
    run_window(1'b1, "gap");

    for (int i = 0; i < FRAME && !(h_m == 10 && v_m == 5); i++) step(1'b1);
    pix_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_obs", obs, 16'h6000);
    chk("mrst_row", row_read, 0);
    chk("mrst_col", col_read, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_model();
    repeat (2 * HT) step(1'b1);
    chk("mrst_fs_idx", first_fs, RL + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
